// File: rtl/mspu_stream_pkg.sv
// Shared types and helpers for the MSPE stream gatherer/distributor blocks.
package mspu_stream_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_HDR,
    ST_SEND
  } state_e;

  localparam int unsigned DEF_LEN_W   = 16;
  localparam int unsigned DEF_MAX_LEN = 1024;

  // Pointer width for an n-entry round robin; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Payload length carried in the low len_w bits of a header word.
  function automatic logic [31:0] hdr_len(input logic [31:0] hdr_lo,
                                          input int unsigned len_w);
    logic [31:0] mask;
    mask = (len_w >= 32) ? '1 : ((32'd1 << len_w) - 32'd1);
    return hdr_lo & mask;
  endfunction

endpackage

// File: rtl/mspe_rr_ptr.sv
// Round-robin index that steps by one on adv_i and wraps N-1 -> 0.
module mspe_rr_ptr
  import mspu_stream_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                adv_i,
  output logic [ptr_w(N)-1:0] ptr_o
);

  localparam int unsigned     PW   = ptr_w(N);
  localparam logic [PW-1:0]   LAST = PW'(N - 1);

  logic [PW-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (adv_i) begin
      ptr_q <= (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/mspe_src_arbiter.sv
// Round-robin packet gatherer: drains length-headed packets from per-core
// FWFT FIFOs onto a single Avalon-ST stream with ready backpressure.
module mspe_src_arbiter
  import mspu_stream_pkg::*;
#(
  parameter int unsigned CORES   = 4,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned FWD_HDR = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CORES-1:0]          core_en,
  input  logic [CORES*DATA_W-1:0]   fifo_q,
  input  logic [CORES*CNT_W-1:0]    fifo_count,
  output logic [CORES-1:0]          fifo_re,
  output logic [DATA_W-1:0]         src_data,
  output logic                      src_valid,
  output logic                      src_sop,
  output logic                      src_eop,
  input  logic                      src_ready,
  output logic [ptr_w(CORES)-1:0]   cur_core,
  output logic                      busy,
  output logic [CORES-1:0]          len_err,
  output logic [31:0]               pkt_cnt
);

  localparam int unsigned PW   = ptr_w(CORES);
  localparam int unsigned CW1  = CNT_W + 1;
  localparam int unsigned LO_W = (DATA_W < 32) ? DATA_W : 32;
  localparam logic [LEN_W:0] REM_ONE = (LEN_W + 1)'(1);

  state_e              state_q;
  logic [LEN_W:0]      rem_q;
  logic                first_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic                sop_q;
  logic                eop_q;
  logic [CORES-1:0]    len_err_q;
  logic [31:0]         pkt_cnt_q;

  logic [PW-1:0]       ptr;
  logic                adv;
  logic                pop;
  logic [CORES-1:0]    sel_oh;
  logic [DATA_W-1:0]   q_sel;
  logic [CNT_W-1:0]    cnt_sel;
  logic [31:0]         hdr_lo;
  logic [31:0]         len32;
  logic [LEN_W-1:0]    len;
  logic [CW1-1:0]      need;
  logic                en_sel;
  logic                has_data;
  logic                len_big;
  logic                complete;
  logic                load;
  logic                done;

  mspe_rr_ptr #(.N(CORES)) u_ptr (
    .clk   (clk),
    .reset (reset),
    .adv_i (adv),
    .ptr_o (ptr)
  );

  assign sel_oh   = CORES'(1) << ptr;
  assign q_sel    = fifo_q[ptr*DATA_W +: DATA_W];
  assign cnt_sel  = fifo_count[ptr*CNT_W +: CNT_W];
  assign en_sel   = |(core_en & sel_oh);
  assign has_data = (cnt_sel != '0);
  assign hdr_lo   = 32'(q_sel[LO_W-1:0]);
  assign len32    = hdr_len(hdr_lo, LEN_W);
  assign len      = len32[LEN_W-1:0];
  assign len_big  = (len32 > MAX_LEN);
  // len+1 evaluated one bit wider than the count so a full count cannot wrap.
  assign need     = CW1'(len) + CW1'(1);
  assign complete = ({1'b0, cnt_sel} >= need);
  assign load     = (state_q == ST_SEND) && (rem_q != '0) && (!valid_q || src_ready);
  assign done     = (state_q == ST_SEND) && valid_q && src_ready && eop_q;

  always_comb begin
    pop = 1'b0;
    adv = 1'b0;
    case (state_q)
      ST_SCAN: adv = !(en_sel && has_data);
      ST_HDR: begin
        if (len_big) begin
          pop = 1'b1;
          adv = 1'b1;
        end else if (!complete) begin
          adv = 1'b1;
        end else if (FWD_HDR == 0) begin
          pop = 1'b1;
          adv = (len == '0);
        end
      end
      ST_SEND: begin
        pop = load;
        adv = done;
      end
      default: ;
    endcase
  end

  assign fifo_re = pop ? sel_oh : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_SCAN;
      rem_q     <= '0;
      first_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      len_err_q <= '0;
      pkt_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (en_sel && has_data) state_q <= ST_HDR;
        end
        ST_HDR: begin
          if (len_big) begin
            len_err_q <= len_err_q | sel_oh;
            state_q   <= ST_SCAN;
          end else if (!complete) begin
            state_q <= ST_SCAN;
          end else if (FWD_HDR != 0) begin
            rem_q   <= {1'b0, len} + REM_ONE;
            first_q <= 1'b1;
            state_q <= ST_SEND;
          end else if (len == '0) begin
            state_q <= ST_SCAN;
          end else begin
            rem_q   <= {1'b0, len};
            first_q <= 1'b1;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (load) begin
            data_q  <= q_sel;
            valid_q <= 1'b1;
            sop_q   <= first_q;
            eop_q   <= (rem_q == REM_ONE);
            rem_q   <= rem_q - REM_ONE;
            first_q <= 1'b0;
          end else if (src_ready) begin
            valid_q <= 1'b0;
          end
          if (done) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
            state_q   <= ST_SCAN;
          end
        end
        default: state_q <= ST_SCAN;
      endcase
    end
  end

  assign src_data  = data_q;
  assign src_valid = valid_q;
  assign src_sop   = sop_q;
  assign src_eop   = eop_q;
  assign cur_core  = ptr;
  assign busy      = (state_q != ST_SCAN);
  assign len_err   = len_err_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule
